// File: rtl/bs_lfsr_pkg.sv
// Shared types, default tap table and combinational helpers for the
// bit-swapping LFSR test-pattern generator.
package bs_lfsr_pkg;

  // Run-control FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tpg_state_e;

  // Helpers work on a fixed maximum width; callers zero-extend and truncate.
  localparam int LFSR_MAX_W = 64;
  localparam int POP_W      = $clog2(LFSR_MAX_W + 1);

  // Galois feedback masks of primitive polynomials for common widths.
  localparam logic [31:0] TAPS_W4  = 32'h0000_000C;
  localparam logic [31:0] TAPS_W8  = 32'h0000_00B8;
  localparam logic [31:0] TAPS_W16 = 32'h0000_B400;
  localparam logic [31:0] TAPS_W32 = 32'h8020_0003;

  // Default mask for a width; unsupported widths return 0 and must be
  // overridden with an explicit TAPS parameter.
  function automatic logic [31:0] default_taps(input int width);
    logic [31:0] t;
    case (width)
      4:       t = TAPS_W4;
      8:       t = TAPS_W8;
      16:      t = TAPS_W16;
      32:      t = TAPS_W32;
      default: t = 32'h0;
    endcase
    return t;
  endfunction

  // One Galois step: shift right, fold the taps in when bit 0 falls out.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
    input logic [LFSR_MAX_W-1:0] s,
    input logic [LFSR_MAX_W-1:0] taps
  );
    return (s >> 1) ^ (s[0] ? taps : '0);
  endfunction

  // Output transform: when enabled and bit 0 is clear, exchange each pair
  // (2k+1, 2k+2) that fits inside the width. Bit 0 never moves.
  function automatic logic [LFSR_MAX_W-1:0] swap_pat(
    input logic [LFSR_MAX_W-1:0] s,
    input int                    width,
    input logic                  en
  );
    logic [LFSR_MAX_W-1:0] r;
    r = s;
    if (en && !s[0]) begin
      for (int k = 0; 2 * k + 2 < LFSR_MAX_W; k++) begin
        if (2 * k + 2 <= width - 1) begin
          r[2*k+1] = s[2*k+2];
          r[2*k+2] = s[2*k+1];
        end
      end
    end
    return r;
  endfunction

  // Number of set bits, used for toggle counting between patterns.
  function automatic logic [POP_W-1:0] popcount(input logic [LFSR_MAX_W-1:0] v);
    logic [POP_W-1:0] c;
    c = '0;
    for (int i = 0; i < LFSR_MAX_W; i++) begin
      c = c + POP_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/bs_lfsr_tpg_if.sv
// Controller and pattern-stream signals of the test-pattern generator.
// master is the generator side, slave is the BIST controller / consumer side.
interface bs_lfsr_tpg_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16,
  parameter int TC_W  = 24
);

  logic             seed_load;
  logic [WIDTH-1:0] seed_in;
  logic             swap_en;
  logic             start;
  logic [CNT_W-1:0] num_pat;
  logic             pat_ready;

  logic             pat_valid;
  logic [WIDTH-1:0] pat;
  logic             busy;
  logic             done;
  logic [TC_W-1:0]  trans_cnt;
  logic [WIDTH-1:0] lfsr_state;

  modport master (
    input  seed_load, seed_in, swap_en, start, num_pat, pat_ready,
    output pat_valid, pat, busy, done, trans_cnt, lfsr_state
  );

  modport slave (
    output seed_load, seed_in, swap_en, start, num_pat, pat_ready,
    input  pat_valid, pat, busy, done, trans_cnt, lfsr_state
  );

endinterface

// File: rtl/bs_lfsr_core.sv
// LFSR state register with seed load and step control, plus the
// combinational step and output-swap logic seen by the top level.
module bs_lfsr_core
  import bs_lfsr_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             advance,
  input  logic             swap_sel,
  output logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] cur_pat,
  output logic [WIDTH-1:0] next_pat
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] eff_state;
  logic [WIDTH-1:0] step_val;

  // An all-zero state would lock the LFSR, so a zero seed becomes 1.
  assign load_val  = (seed_in == '0) ? WIDTH'(1) : seed_in;

  // A seed loaded in the same cycle as start is what the first pattern uses.
  assign eff_state = load ? load_val : state_q;

  assign step_val  = WIDTH'(lfsr_next(LFSR_MAX_W'(state_q), LFSR_MAX_W'(TAPS)));
  assign cur_pat   = WIDTH'(swap_pat(LFSR_MAX_W'(eff_state), WIDTH, swap_sel));
  assign next_pat  = WIDTH'(swap_pat(LFSR_MAX_W'(step_val), WIDTH, swap_sel));
  assign state     = state_q;

  // State register: seed load has priority, otherwise step on an accepted pattern.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEED;
    end else if (load) begin
      state_q <= load_val;
    end else if (advance) begin
      state_q <= step_val;
    end
  end

endmodule

// File: rtl/bs_lfsr_tpg.sv
// Bit-swapping LFSR test-pattern generator: run-control FSM, pattern
// register with valid/ready output, remaining-pattern counter and a
// saturating count of bit toggles between consecutive patterns.
module bs_lfsr_tpg
  import bs_lfsr_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
  parameter int               CNT_W = 16,
  parameter int               TC_W  = 24
) (
  input  logic          clk,
  input  logic          rst,
  bs_lfsr_tpg_if.master bus
);

  localparam int SUM_W = ((TC_W > POP_W) ? TC_W : POP_W) + 1;
  localparam logic [SUM_W-1:0] TC_MAX_EXT = SUM_W'({TC_W{1'b1}});

  tpg_state_e       fsm_q;
  tpg_state_e       fsm_d;

  logic [WIDTH-1:0] pat_q;
  logic             pat_valid_q;
  logic [CNT_W-1:0] rem_q;
  logic             swap_r;
  logic [TC_W-1:0]  trans_cnt_q;

  logic             accept;
  logic             core_load;
  logic             core_adv;
  logic             swap_sel;
  logic             start_run;
  logic             start_empty;
  logic             adv_more;
  logic             adv_last;
  logic             busy;
  logic             done;

  logic [WIDTH-1:0] lfsr_state;
  logic [WIDTH-1:0] cur_pat;
  logic [WIDTH-1:0] next_pat;
  logic [POP_W-1:0] toggles;
  logic [SUM_W-1:0] tc_sum;
  logic [TC_W-1:0]  tc_next;

  assign accept    = pat_valid_q & bus.pat_ready;
  assign core_load = (fsm_q == IDLE) & bus.seed_load;
  assign core_adv  = adv_more | adv_last;

  // While idle the incoming swap_en shapes the first pattern; during a run
  // the value captured at start is used.
  assign swap_sel  = (fsm_q == IDLE) ? bus.swap_en : swap_r;

  bs_lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (core_load),
    .seed_in  (bus.seed_in),
    .advance  (core_adv),
    .swap_sel (swap_sel),
    .state    (lfsr_state),
    .cur_pat  (cur_pat),
    .next_pat (next_pat)
  );

  assign toggles = popcount(LFSR_MAX_W'(pat_q ^ next_pat));
  assign tc_sum  = SUM_W'(trans_cnt_q) + SUM_W'(toggles);
  assign tc_next = (tc_sum > TC_MAX_EXT) ? {TC_W{1'b1}} : tc_sum[TC_W-1:0];

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q <= IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // Next-state decode, datapath strobes and status outputs.
  always_comb begin
    fsm_d       = fsm_q;
    start_run   = 1'b0;
    start_empty = 1'b0;
    adv_more    = 1'b0;
    adv_last    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.num_pat != '0) begin
            fsm_d     = RUN;
            start_run = 1'b1;
          end else begin
            fsm_d       = DONE;
            start_empty = 1'b1;
          end
        end
      end
      RUN: begin
        busy = 1'b1;
        if (accept) begin
          if (rem_q == CNT_W'(1)) begin
            fsm_d    = DONE;
            adv_last = 1'b1;
          end else begin
            adv_more = 1'b1;
          end
        end
      end
      DONE: begin
        done  = 1'b1;
        fsm_d = IDLE;
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  // Pattern register, remaining count, swap mode and toggle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q       <= '0;
      pat_valid_q <= 1'b0;
      rem_q       <= '0;
      swap_r      <= 1'b0;
      trans_cnt_q <= '0;
    end else if (start_run) begin
      rem_q       <= bus.num_pat;
      swap_r      <= bus.swap_en;
      trans_cnt_q <= '0;
      pat_q       <= cur_pat;
      pat_valid_q <= 1'b1;
    end else if (start_empty) begin
      trans_cnt_q <= '0;
    end else if (adv_last) begin
      rem_q       <= rem_q - CNT_W'(1);
      pat_valid_q <= 1'b0;
    end else if (adv_more) begin
      rem_q       <= rem_q - CNT_W'(1);
      pat_q       <= next_pat;
      trans_cnt_q <= tc_next;
    end
  end

  assign bus.pat_valid  = pat_valid_q;
  assign bus.pat        = pat_q;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.trans_cnt  = trans_cnt_q;
  assign bus.lfsr_state = lfsr_state;

endmodule

// File: tb/tb_bs_lfsr_tpg.sv
// Scoreboard bench for bs_lfsr_tpg at WIDTH=4. A second instance with a
// 3-bit transition counter shares the stimulus to exercise saturation.
module tb_bs_lfsr_tpg;

  localparam int         W       = 4;
  localparam logic [3:0] TB_TAPS = 4'b1100;
  localparam logic [3:0] TB_SEED = 4'b0001;
  localparam int         CNT_W   = 16;
  localparam int         TC_W    = 24;
  localparam int         TC_W_S  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  bs_lfsr_tpg_if #(.WIDTH(W), .CNT_W(CNT_W), .TC_W(TC_W))   bus ();
  bs_lfsr_tpg_if #(.WIDTH(W), .CNT_W(CNT_W), .TC_W(TC_W_S)) bus_s ();

  assign bus_s.seed_load = bus.seed_load;
  assign bus_s.seed_in   = bus.seed_in;
  assign bus_s.swap_en   = bus.swap_en;
  assign bus_s.start     = bus.start;
  assign bus_s.num_pat   = bus.num_pat;
  assign bus_s.pat_ready = bus.pat_ready;

  bs_lfsr_tpg #(.WIDTH(W), .TAPS(TB_TAPS), .SEED(TB_SEED), .CNT_W(CNT_W), .TC_W(TC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  bs_lfsr_tpg #(.WIDTH(W), .TAPS(TB_TAPS), .SEED(TB_SEED), .CNT_W(CNT_W), .TC_W(TC_W_S)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  typedef struct {
    logic [W-1:0] pat;
    logic [W-1:0] raw;
    longint       tc;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] m_state;
  longint       m_final;
  int           checks = 0;
  int           errors = 0;

  // Reference LFSR step from the Galois rule.
  function automatic logic [W-1:0] m_step(input logic [W-1:0] s);
    return (s >> 1) ^ (s[0] ? TB_TAPS : 4'b0000);
  endfunction

  // Reference swap: walk adjacent odd/even pairs above bit 0.
  function automatic logic [W-1:0] m_swap(input logic [W-1:0] s, input logic sw);
    logic [W-1:0] r;
    r = s;
    if (sw && !s[0]) begin
      for (int j = 1; j + 1 < W; j += 2) begin
        r[j]   = s[j+1];
        r[j+1] = s[j];
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] satTo(input longint v, input int bits);
    longint mx;
    mx = (longint'(1) << bits) - 1;
    return 32'((v > mx) ? mx : v);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: whenever a pattern is presented, compare against the queue head;
  // pop it on an accept.
  always @(negedge clk) begin
    if (!rst && bus.pat_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_pattern: got %0h expected none at %0t", bus.pat, $time);
      end else begin
        checkOutput("pat", 32'(bus.pat), 32'(exp_q[0].pat));
        checkOutput("pat_sat_inst", 32'(bus_s.pat), 32'(exp_q[0].pat));
        checkOutput("lfsr_state", 32'(bus.lfsr_state), 32'(exp_q[0].raw));
        checkOutput("trans_cnt", 32'(bus.trans_cnt), satTo(exp_q[0].tc, TC_W));
        checkOutput("trans_cnt_sat", 32'(bus_s.trans_cnt), satTo(exp_q[0].tc, TC_W_S));
        checkOutput("busy_run", 32'(bus.busy), 32'd1);
        if (bus.pat_ready) begin
          void'(exp_q.pop_front());
        end
      end
    end
  end

  function automatic logic readyFor(input int mode, input int cyc);
    logic r;
    case (mode)
      0:       r = 1'b1;
      2:       r = (cyc >= 5);
      default: r = ($urandom_range(0, 3) != 0);
    endcase
    return r;
  endfunction

  // Issue one run: load the model's expectations, start, then wait for done.
  // ready_mode: 0 always ready, 1 random, 2 held low for 5 cycles first.
  task automatic applyStimulus(input int n, input logic sw, input logic do_seed,
                               input logic [W-1:0] seed, input int ready_mode);
    logic [W-1:0] s;
    logic [W-1:0] p;
    logic [W-1:0] prev_p;
    longint       cum;
    exp_t         e;
    int           cyc;
    int           acc;
    logic         prev_acc;
    logic         seen;

    if (do_seed) m_state = (seed == '0) ? 4'b0001 : seed;
    s      = m_state;
    cum    = 0;
    prev_p = '0;
    for (int i = 0; i < n; i++) begin
      p = m_swap(s, sw);
      if (i > 0) cum += $countones(p ^ prev_p);
      e.pat = p;
      e.raw = s;
      e.tc  = cum;
      exp_q.push_back(e);
      prev_p = p;
      s      = m_step(s);
    end
    m_state = s;
    m_final = cum;

    @(posedge clk); #1;
    bus.seed_load = do_seed;
    bus.seed_in   = seed;
    bus.start     = 1'b1;
    bus.num_pat   = CNT_W'(n);
    bus.swap_en   = sw;
    @(posedge clk); #1;
    bus.seed_load = 1'b0;
    bus.seed_in   = 4'($urandom_range(0, 15));
    bus.start     = 1'b0;
    bus.swap_en   = 1'($urandom_range(0, 1));
    bus.pat_ready = readyFor(ready_mode, 0);

    cyc      = 0;
    acc      = 0;
    prev_acc = 1'b0;
    seen     = 1'b0;
    @(negedge clk);
    checkOutput("first_valid_latency", 32'(bus.pat_valid), 32'(n != 0));
    while (!seen && cyc < 2000) begin
      if (bus.done) begin
        seen = 1'b1;
        checkOutput("done_accept_count", 32'(acc), 32'(n));
        if (n > 0) checkOutput("done_after_last_accept", 32'(prev_acc), 32'd1);
        checkOutput("done_busy", 32'(bus.busy), 32'd0);
        checkOutput("done_valid", 32'(bus.pat_valid), 32'd0);
      end else begin
        if (ready_mode == 2 && cyc < 5) begin
          checkOutput("bp_hold_valid", 32'(bus.pat_valid), 32'd1);
        end
        prev_acc = bus.pat_valid && bus.pat_ready;
        if (prev_acc) acc++;
        @(posedge clk); #1;
        cyc++;
        bus.pat_ready = readyFor(ready_mode, cyc);
        @(negedge clk);
      end
    end

    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: got no done expected done within 2000 cycles");
      exp_q.delete();
    end else begin
      @(negedge clk);
      checkOutput("done_one_cycle", 32'(bus.done), 32'd0);
      checkOutput("idle_trans_cnt", 32'(bus.trans_cnt), satTo(m_final, TC_W));
      checkOutput("idle_trans_cnt_sat", 32'(bus_s.trans_cnt), satTo(m_final, TC_W_S));
      checkOutput("idle_lfsr_state", 32'(bus.lfsr_state), 32'(m_state));
      checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    end
    bus.pat_ready = 1'b0;
  endtask

  // Load a zero seed while idle; it must be forced to 1.
  task automatic zeroSeed();
    @(posedge clk); #1;
    bus.seed_load = 1'b1;
    bus.seed_in   = '0;
    @(posedge clk); #1;
    bus.seed_load = 1'b0;
    @(negedge clk);
    m_state = 4'b0001;
    checkOutput("zero_seed_state", 32'(bus.lfsr_state), 32'(m_state));
  endtask

  // Start a 10-pattern run and pull reset after three accepts.
  task automatic resetMidRun();
    logic [W-1:0] s;
    logic         sw;
    exp_t         e;
    int           acc;

    sw = 1'($urandom_range(0, 1));
    s  = m_state;
    for (int i = 0; i < 10; i++) begin
      e.pat = m_swap(s, sw);
      e.raw = s;
      e.tc  = 0;
      if (i > 0) e.tc = exp_q[exp_q.size()-1].tc + $countones(e.pat ^ exp_q[exp_q.size()-1].pat);
      exp_q.push_back(e);
      s = m_step(s);
    end

    @(posedge clk); #1;
    bus.start   = 1'b1;
    bus.num_pat = CNT_W'(10);
    bus.swap_en = sw;
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.pat_ready = 1'b1;
    acc = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.pat_valid && bus.pat_ready) acc++;
    end
    checkOutput("reset_pre_accepts", 32'(acc), 32'd3);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_valid", 32'(bus.pat_valid), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_pat", 32'(bus.pat), 32'd0);
    checkOutput("rst_state", 32'(bus.lfsr_state), 32'(TB_SEED));
    checkOutput("rst_trans_cnt", 32'(bus.trans_cnt), 32'd0);
    checkOutput("rst_trans_cnt_sat", 32'(bus_s.trans_cnt), 32'd0);
    bus.pat_ready = 1'b0;
    exp_q.delete();
    m_state = TB_SEED;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_no_done", 32'(bus.done), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_no_done", 32'(bus.done), 32'd0);
  endtask

  initial begin
    bus.seed_load = 1'b0;
    bus.seed_in   = '0;
    bus.swap_en   = 1'b0;
    bus.start     = 1'b0;
    bus.num_pat   = '0;
    bus.pat_ready = 1'b0;
    m_state       = TB_SEED;
    m_final       = 0;

    #23;
    checkOutput("reset_valid", 32'(bus.pat_valid), 32'd0);
    checkOutput("reset_pat", 32'(bus.pat), 32'd0);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_done", 32'(bus.done), 32'd0);
    checkOutput("reset_trans_cnt", 32'(bus.trans_cnt), 32'd0);
    checkOutput("reset_state", 32'(bus.lfsr_state), 32'(TB_SEED));
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] full-period sequence");
    applyStimulus(15, 1'b0, 1'b0, '0, 0);
    $display("[TB] swap mode");
    applyStimulus(4, 1'b1, 1'b0, '0, 0);
    $display("[TB] backpressure with seed and start together");
    applyStimulus(3, 1'b0, 1'b1, 4'b0001, 2);
    $display("[TB] zero seed and empty run");
    zeroSeed();
    applyStimulus(0, 1'b0, 1'b0, '0, 0);
    $display("[TB] saturation run");
    applyStimulus(8, 1'b0, 1'b0, '0, 0);
    $display("[TB] reset mid-run");
    resetMidRun();
    $display("[TB] randomized runs");
    for (int r = 0; r < 12; r++) begin
      applyStimulus($urandom_range(0, 20), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), 1);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
